// File: rtl/fetch_queue.sv
// Instruction fetch queue: PC register, combinational ROM lookup, DEPTH-entry FIFO of {inst, pc+4}.
// Define FETCH_QUEUE_PERF_EN to add the full-cycle and flush performance counters.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     halt,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [9:0]               rom_addr,
  input  logic [31:0]              rom_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic [31:0]              out_pc4,
  output logic [$clog2(DEPTH):0]   fill
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]              perf_full_cycles,
  output logic [31:0]              perf_flush_cnt
`endif
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [31:0]   r_pc;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_fill;
  logic [31:0]   r_inst [DEPTH];
  logic [31:0]   r_pc4  [DEPTH];

  logic          w_active;
  logic          w_pop;
  logic          w_push;
  logic [31:0]   w_pc_next;

  assign w_active  = ~halt & ~redirect;
  assign w_pop     = w_active & out_valid & out_ready;
  assign w_push    = w_active & ((r_fill != FULL) | w_pop);
  assign w_pc_next = r_pc + 32'd4;

  assign rom_addr  = r_pc[11:2];
  assign fill      = r_fill;
  assign out_valid = (r_fill != '0);
  // Empty queue presents a zero bubble; head storage may hold stale data.
  assign out_inst  = out_valid ? r_inst[r_head] : 32'h0;
  assign out_pc4   = out_valid ? r_pc4[r_head]  : 32'h0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= RESET_PC;
      r_fill <= '0;
      r_head <= '0;
      r_tail <= '0;
    end else if (!halt) begin
      if (redirect) begin
        r_fill <= '0;
        r_head <= r_tail;
        r_pc   <= redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (w_push) begin
          r_tail <= r_tail + AW'(1);
          r_pc   <= w_pc_next;
        end
        if (w_pop) begin
          r_head <= r_head + AW'(1);
        end
        if (w_push && !w_pop) begin
          r_fill <= r_fill + (AW+1)'(1);
        end else if (w_pop && !w_push) begin
          r_fill <= r_fill - (AW+1)'(1);
        end
      end
    end
  end

  // NOTE: entry storage has no reset; occupancy alone decides validity, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst[r_tail] <= rom_data;
      r_pc4[r_tail]  <= w_pc_next;
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] r_perf_full;
  logic [31:0] r_perf_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_full  <= '0;
      r_perf_flush <= '0;
    end else if (!halt) begin
      if (r_fill == FULL) begin
        r_perf_full <= r_perf_full + 32'd1;
      end
      if (redirect) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign perf_full_cycles = r_perf_full;
  assign perf_flush_cnt   = r_perf_flush;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, corner-case sequences and random traffic
// against a queue-based reference model. ROM word k holds the value k.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic                   clk;
  logic                   rst;
  logic                   halt;
  logic                   redirect;
  logic [31:0]            redirect_pc;
  logic [9:0]             rom_addr;
  logic [31:0]            rom_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_inst;
  logic [31:0]            out_pc4;
  logic [$clog2(DEPTH):0] fill;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0]            perf_full_cycles;
  logic [31:0]            perf_flush_cnt;
`endif

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .halt        (halt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc4     (out_pc4),
    .fill        (fill)
`ifdef FETCH_QUEUE_PERF_EN
    ,
    .perf_full_cycles (perf_full_cycles),
    .perf_flush_cnt   (perf_flush_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rom_word(input logic [9:0] a);
    return {22'h0, a};
  endfunction

  assign rom_data = rom_word(rom_addr);

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
  } ent_t;

  typedef struct {
    logic        rst;
    logic        halt;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc4;
    int          fill;
    logic [9:0]  addr;
  } vec_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_full;
  logic [31:0] m_flush;
  int          n_cmp;
  int          n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic h, input logic d,
                       input logic [31:0] pc, input logic y);
    rst         = r;
    halt        = h;
    redirect    = d;
    redirect_pc = pc;
    out_ready   = y;
  endtask

  task automatic check_model();
    logic [31:0] e_inst;
    logic [31:0] e_pc4;
    e_inst = (mq.size() != 0) ? mq[0].inst : 32'h0;
    e_pc4  = (mq.size() != 0) ? mq[0].pc4  : 32'h0;
    check("m_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("m_inst",  out_inst, e_inst);
    check("m_pc4",   out_pc4,  e_pc4);
    check("m_fill",  32'(fill), 32'(mq.size()));
    check("m_addr",  32'(rom_addr), 32'(m_pc[11:2]));
`ifdef FETCH_QUEUE_PERF_EN
    check("m_perf_full",  perf_full_cycles, m_full);
    check("m_perf_flush", perf_flush_cnt,   m_flush);
`endif
  endtask

  task automatic model_update();
    bit   do_pop;
    bit   do_push;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_pc    = RESET_PC;
      m_full  = 32'h0;
      m_flush = 32'h0;
    end else if (!halt) begin
      if (mq.size() == DEPTH) m_full++;
      if (redirect) begin
        m_flush++;
        mq.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        do_pop  = (mq.size() > 0) && out_ready;
        do_push = (mq.size() < DEPTH) || do_pop;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          e.inst = rom_word(m_pc[11:2]);
          e.pc4  = m_pc + 32'd4;
          mq.push_back(e);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  // Inputs already driven: compare against the model, advance model and DUT by one edge.
  task automatic finish_cycle();
    check_model();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic r, input logic h, input logic d,
                      input logic [31:0] pc, input logic y);
    drive(r, h, d, pc, y);
    #1;
    finish_cycle();
  endtask

  vec_t tbl[12];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,  32'h0,   0, 10'h000};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,  32'h4,   1, 10'h001};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h1,  32'h8,   1, 10'h002};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h2,  32'hC,   1, 10'h003};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h2,  32'hC,   2, 10'h004};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'h103, 1'b1, 1'b1, 32'h2,  32'hC,   3, 10'h005};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,  32'h0,   0, 10'h040};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'h0,   1'b1, 1'b1, 32'h40, 32'h104, 1, 10'h041};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h40, 32'h104, 1, 10'h041};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h41, 32'h108, 1, 10'h042};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,  32'h0,   0, 10'h000};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,  32'h4,   1, 10'h001};

    // Initial reset: outputs are unknown until the first edge, so the model is only seeded.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    model_update();

    // Directed vectors: fetch stream, back-pressure, redirect to 0x103, halt, reset under halt.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].rst, tbl[i].halt, tbl[i].redir, tbl[i].rpc, tbl[i].rdy);
      #1;
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(tbl[i].valid));
      check($sformatf("v%0d_inst", i),  out_inst, tbl[i].inst);
      check($sformatf("v%0d_pc4", i),   out_pc4,  tbl[i].pc4);
      check($sformatf("v%0d_fill", i),  32'(fill), 32'(tbl[i].fill));
      check($sformatf("v%0d_addr", i),  32'(rom_addr), 32'(tbl[i].addr));
      finish_cycle();
    end

    // Stall the consumer for 10 cycles: queue fills to DEPTH, pc stops at 16, then drains gaplessly.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("stall_fill", 32'(fill), 32'd4);
    check("stall_addr", 32'(rom_addr), 32'd4);
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      #1;
      check($sformatf("drain%0d_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("drain%0d_inst", k),  out_inst, 32'(k));
      check($sformatf("drain%0d_pc4", k),   out_pc4,  32'(4 * k + 4));
      finish_cycle();
    end

    // Redirect on a full queue with the consumer ready: everything discarded, nothing popped.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("full_fill", 32'(fill), 32'(DEPTH));
    step(1'b0, 1'b0, 1'b1, 32'h200, 1'b1);
    check("flush_fill",  32'(fill), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_addr",  32'(rom_addr), 32'h80);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("flush_tgt_inst", out_inst, 32'h80);
    check("flush_tgt_pc4",  out_pc4,  32'h204);

    // Halt for 5 cycles with redirect and out_ready toggling: state frozen.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, i[0], 32'h300, ~i[0]);
    check("halt_fill", 32'(fill), 32'd3);
    check("halt_addr", 32'(rom_addr), 32'd3);
    check("halt_inst", out_inst, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Reset while halted with two entries queued.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("prerst_fill", 32'(fill), 32'd2);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    check("rst_fill",  32'(fill), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_addr",  32'(rom_addr), 32'(RESET_PC[11:2]));
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("rst_first_inst", out_inst, rom_word(RESET_PC[11:2]));
    check("rst_first_pc4",  out_pc4,  RESET_PC + 32'd4);

    // Random traffic against the reference model, including pc wrap through redirect targets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 20),
           ($urandom_range(0, 99) < 10),
           (i % 7 == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom,
           ($urandom_range(0, 99) < 60));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
